// File: rtl/regfile_writeback_if.sv
// regfile_writeback_if: result sources, hazard query and register-file write port
interface regfile_writeback_if #(
    parameter int XLEN = 32,
    parameter int AW   = 5
);
    logic            flush;
    logic            iss_valid;
    logic [AW-1:0]   iss_rd;
    logic            alu_valid;
    logic [AW-1:0]   alu_rd;
    logic [XLEN-1:0] alu_data;
    logic            lsu_valid;
    logic            lsu_ready;
    logic [AW-1:0]   lsu_rd;
    logic [XLEN-1:0] lsu_rdata;
    logic [2:0]      lsu_funct3;
    logic [1:0]      lsu_boff;
    logic [AW-1:0]   rs1;
    logic [AW-1:0]   rs2;
    logic            rs1_busy;
    logic            rs2_busy;
    logic            rd_wen;
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] rd_data;
    logic            wb_err;

    modport master (
        input  flush, iss_valid, iss_rd, alu_valid, alu_rd, alu_data,
               lsu_valid, lsu_rd, lsu_rdata, lsu_funct3, lsu_boff, rs1, rs2,
        output lsu_ready, rs1_busy, rs2_busy, rd_wen, rd, rd_data, wb_err
    );

    modport slave (
        output flush, iss_valid, iss_rd, alu_valid, alu_rd, alu_data,
               lsu_valid, lsu_rd, lsu_rdata, lsu_funct3, lsu_boff, rs1, rs2,
        input  lsu_ready, rs1_busy, rs2_busy, rd_wen, rd, rd_data, wb_err
    );
endinterface

// File: rtl/regfile_writeback.sv
// regfile_writeback: ALU/LSU result arbitration, load extension, registered write port and busy scoreboard
module regfile_writeback #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int AW    = 5
) (
    input logic CLK,
    input logic RSTN,
    regfile_writeback_if.master bus
);
    localparam logic [NREGS-1:0] ONE = NREGS'(1);

    logic [NREGS-1:0] busy, busy_n, set_m, clr_m;
    logic             acc_lsu, acc, legal, wen_n, err_n;
    logic [AW-1:0]    win_rd;
    logic [7:0]       ld_b;
    logic [15:0]      ld_h;
    logic [XLEN-1:0]  ld_data, win_data;
    logic             rd_wen_q, wb_err_q;
    logic [AW-1:0]    rd_q;
    logic [XLEN-1:0]  rd_data_q;

    // arbitration, load extension and next scoreboard; set beats clear, x0 never busy
    always_comb begin
        acc_lsu  = bus.lsu_valid & ~bus.alu_valid;
        acc      = bus.alu_valid | acc_lsu;
        legal    = bus.lsu_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        ld_b     = bus.lsu_rdata[{bus.lsu_boff, 3'b000} +: 8];
        ld_h     = bus.lsu_rdata[{bus.lsu_boff[1], 4'b0000} +: 16];
        ld_data  = bus.lsu_funct3 == 3'b000 ? {{(XLEN-8){ld_b[7]}}, ld_b} :
                   bus.lsu_funct3 == 3'b001 ? {{(XLEN-16){ld_h[15]}}, ld_h} :
                   bus.lsu_funct3 == 3'b100 ? {{(XLEN-8){1'b0}}, ld_b} :
                   bus.lsu_funct3 == 3'b101 ? {{(XLEN-16){1'b0}}, ld_h} : bus.lsu_rdata;
        win_rd   = bus.alu_valid ? bus.alu_rd : bus.lsu_rd;
        win_data = bus.alu_valid ? bus.alu_data : ld_data;
        wen_n    = (bus.alu_valid | (acc_lsu & legal)) & (win_rd != '0);
        err_n    = acc_lsu & ~legal;
        set_m    = (bus.iss_valid & ~bus.flush) ? ONE << bus.iss_rd : '0;
        clr_m    = acc ? ONE << win_rd : '0;
        busy_n   = bus.flush ? '0 : ((busy & ~clr_m) | set_m) & ~ONE;
    end

    // registered write port and scoreboard; rd/rd_data hold between writes
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            rd_wen_q  <= 1'b0;
            wb_err_q  <= 1'b0;
            rd_q      <= '0;
            rd_data_q <= '0;
            busy      <= '0;
        end else begin
            rd_wen_q  <= wen_n;
            wb_err_q  <= err_n;
            busy      <= busy_n;
            if (wen_n) begin
                rd_q      <= win_rd;
                rd_data_q <= win_data;
            end
        end
    end

    assign bus.lsu_ready = ~bus.alu_valid;
    assign bus.rd_wen    = rd_wen_q;
    assign bus.rd        = rd_q;
    assign bus.rd_data   = rd_data_q;
    assign bus.wb_err    = wb_err_q;
    assign bus.rs1_busy  = busy[bus.rs1] | (rd_wen_q & (rd_q == bus.rs1));
    assign bus.rs2_busy  = busy[bus.rs2] | (rd_wen_q & (rd_q == bus.rs2));
endmodule

// File: tb/tb_regfile_writeback.sv
// tb_regfile_writeback: directed and random stimulus against a behavioural writeback/scoreboard model
module tb_regfile_writeback;
    typedef struct packed {
        logic        fl;
        logic        iv;
        logic [4:0]  ir;
        logic        av;
        logic [4:0]  ar;
        logic [31:0] ad;
        logic        lv;
        logic [4:0]  lr;
        logic [31:0] lw;
        logic [2:0]  f3;
        logic [1:0]  bo;
        logic [4:0]  r1;
        logic [4:0]  r2;
    } stim_t;

    logic clk = 1'b0;
    logic rstn;
    int   n_vec = 0;
    int   n_err = 0;

    bit          busy_m [32];
    logic        m_wen, m_err;
    logic [4:0]  m_rd;
    logic [31:0] m_data;
    stim_t       s;

    regfile_writeback_if #(.XLEN(32), .AW(5)) bus ();

    regfile_writeback #(.XLEN(32), .NREGS(32), .AW(5)) dut (
        .CLK (clk),
        .RSTN(rstn),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ld_ref(input logic [2:0] f3, input logic [31:0] w, input logic [1:0] bo);
        logic [31:0] b, h;
        b = w >> (8 * bo);
        h = w >> (16 * bo[1]);
        case (f3)
            3'b000:  return 32'($signed(b[7:0]));
            3'b001:  return 32'($signed(h[15:0]));
            3'b100:  return {24'd0, b[7:0]};
            3'b101:  return {16'd0, h[15:0]};
            default: return w;
        endcase
    endfunction

    function automatic logic rs_ref(input logic [4:0] r);
        return r != 0 && (busy_m[r] || (m_wen && m_rd == r));
    endfunction

    task automatic model_reset();
        foreach (busy_m[i]) busy_m[i] = 1'b0;
        m_wen = 1'b0;
        m_err = 1'b0;
    endtask

    task automatic drive(input stim_t t);
        bus.flush      = t.fl;
        bus.iss_valid  = t.iv;
        bus.iss_rd     = t.ir;
        bus.alu_valid  = t.av;
        bus.alu_rd     = t.ar;
        bus.alu_data   = t.ad;
        bus.lsu_valid  = t.lv;
        bus.lsu_rd     = t.lr;
        bus.lsu_rdata  = t.lw;
        bus.lsu_funct3 = t.f3;
        bus.lsu_boff   = t.bo;
        bus.rs1        = t.r1;
        bus.rs2        = t.r2;
    endtask

    task automatic cyc(input stim_t t);
        logic       acc, legal;
        logic [4:0] wr;
        @(negedge clk);
        drive(t);
        #1;
        chk("lsu_ready", bus.lsu_ready, !t.av);
        chk("rs1_busy", bus.rs1_busy, rs_ref(t.r1));
        chk("rs2_busy", bus.rs2_busy, rs_ref(t.r2));
        @(posedge clk);
        acc   = t.av || t.lv;
        wr    = t.av ? t.ar : t.lr;
        legal = t.av || (t.f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        m_err = t.lv && !t.av && !legal;
        m_wen = acc && legal && wr != 0;
        if (m_wen) begin
            m_rd   = wr;
            m_data = t.av ? t.ad : ld_ref(t.f3, t.lw, t.bo);
        end
        if (t.fl) foreach (busy_m[i]) busy_m[i] = 1'b0;
        else begin
            if (acc) busy_m[wr] = 1'b0;
            if (t.iv) busy_m[t.ir] = 1'b1;
        end
        busy_m[0] = 1'b0;
        #1;
        chk("rd_wen", bus.rd_wen, m_wen);
        chk("wb_err", bus.wb_err, m_err);
        if (m_wen) begin
            chk("rd", bus.rd, m_rd);
            chk("rd_data", bus.rd_data, m_data);
        end
    endtask

    initial begin
        rstn = 1'b0;
        s = '0;
        drive(s);
        model_reset();
        #23;
        chk("rst_rd_wen", bus.rd_wen, 0);
        chk("rst_rd", bus.rd, 0);
        chk("rst_rd_data", bus.rd_data, 0);
        chk("rst_wb_err", bus.wb_err, 0);
        @(negedge clk);
        rstn = 1'b1;

        for (int i = 0; i < 10; i++) begin
            s = '0;
            s.r1 = 5'($urandom);
            s.r2 = 5'($urandom);
            cyc(s);
            chk("idle_rs1", bus.rs1_busy, 0);
        end

        s = '0; s.iv = 1; s.ir = 5; s.r1 = 5;
        cyc(s);
        for (int i = 0; i < 3; i++) begin
            s = '0; s.r1 = 5;
            cyc(s);
            chk("pend_rs1", bus.rs1_busy, 1);
        end
        s = '0; s.av = 1; s.ar = 5; s.ad = 32'h1234; s.r1 = 5;
        cyc(s);
        chk("alu_wen", bus.rd_wen, 1);
        chk("alu_rd", bus.rd, 5);
        chk("alu_data", bus.rd_data, 32'h0000_1234);
        chk("wthru_rs1", bus.rs1_busy, 1);
        s = '0; s.r1 = 5;
        cyc(s);
        chk("done_rs1", bus.rs1_busy, 0);

        s = '0; s.lv = 1; s.lr = 8; s.lw = 32'h80FF_7F01; s.f3 = 3'b000; s.bo = 3;
        cyc(s);
        chk("lb", bus.rd_data, 32'hFFFF_FF80);
        s.f3 = 3'b100;
        cyc(s);
        chk("lbu", bus.rd_data, 32'h0000_0080);
        s.f3 = 3'b001; s.bo = 2;
        cyc(s);
        chk("lh", bus.rd_data, 32'hFFFF_80FF);
        s.f3 = 3'b101; s.bo = 0;
        cyc(s);
        chk("lhu", bus.rd_data, 32'h0000_7F01);

        s = '0; s.av = 1; s.ar = 3; s.ad = 32'hA; s.lv = 1; s.lr = 4; s.lw = 32'hB; s.f3 = 3'b010;
        cyc(s);
        chk("arb_alu_rd", bus.rd, 3);
        s.av = 0;
        cyc(s);
        chk("arb_lsu_rd", bus.rd, 4);
        chk("arb_lsu_data", bus.rd_data, 32'hB);

        s = '0; s.av = 1; s.ar = 0; s.ad = 32'hDEAD;
        cyc(s);
        chk("x0_wen", bus.rd_wen, 0);
        s = '0; s.iv = 1; s.ir = 0;
        cyc(s);
        s = '0; s.r1 = 0;
        cyc(s);
        chk("x0_busy", bus.rs1_busy, 0);

        s = '0; s.iv = 1; s.ir = 7; s.av = 1; s.ar = 7; s.ad = 32'h77; s.r1 = 7;
        cyc(s);
        s = '0; s.r1 = 7;
        cyc(s);
        chk("setwin_busy", bus.rs1_busy, 1);
        s = '0; s.fl = 1; s.r1 = 7;
        cyc(s);
        chk("flush_busy", bus.rs1_busy, 0);

        s = '0; s.iv = 1; s.ir = 9; s.r1 = 9;
        cyc(s);
        s = '0; s.lv = 1; s.lr = 9; s.lw = 32'h1; s.f3 = 3'b011; s.r1 = 9;
        cyc(s);
        chk("ill_err", bus.wb_err, 1);
        chk("ill_wen", bus.rd_wen, 0);
        chk("ill_busy", bus.rs1_busy, 0);
        s = '0; s.r1 = 9;
        cyc(s);
        chk("ill_pulse", bus.wb_err, 0);

        for (int i = 0; i < 1500; i++) begin
            logic hold;
            hold = s.lv && s.av;
            s.fl = $urandom_range(0, 15) == 0;
            s.iv = $urandom_range(0, 1);
            s.ir = 5'($urandom);
            s.av = $urandom_range(0, 2) == 0;
            s.ar = 5'($urandom);
            s.ad = $urandom;
            s.r1 = 5'($urandom);
            s.r2 = 5'($urandom);
            if (!hold) begin
                s.lv = $urandom_range(0, 1);
                s.lr = 5'($urandom);
                s.lw = $urandom;
                s.f3 = 3'($urandom);
                s.bo = 2'($urandom);
            end
            cyc(s);
        end

        s = '0; s.iv = 1; s.ir = 12;
        cyc(s);
        s = '0; s.av = 1; s.ar = 12; s.ad = 32'hCAFE; s.r1 = 12;
        cyc(s);
        #2;
        rstn = 1'b0;
        #1;
        chk("async_wen", bus.rd_wen, 0);
        chk("async_rd", bus.rd, 0);
        chk("async_data", bus.rd_data, 0);
        chk("async_busy", bus.rs1_busy, 0);
        s = '0; s.r1 = 12;
        drive(s);
        model_reset();
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 4; i++) cyc(s);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
